// File: rtl/dbg_dump_pkg.sv
// ============================================================================
// dbg_dump_pkg : shared types and constants for the register-dump UART path
// Revision: 1.0
// ============================================================================
`default_nettype none

package dbg_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_FINISH  = 3'd5
    } dump_state_t;

    localparam int   BYTES_PER_REG        = 4;
    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;
    localparam int   DATA_BITS            = 8;
    localparam int   DEFAULT_CLKS_PER_BIT = 434;

    // Most significant byte goes out first.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] sel;
        case (idx)
            2'd0:    sel = word[31:24];
            2'd1:    sel = word[23:16];
            2'd2:    sel = word[15:8];
            default: sel = word[7:0];
        endcase
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ============================================================================
// uart_tx_byte : single-byte UART 8N1 transmitter, LSB first
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_byte
    import dbg_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       byte_start,
    input  logic [7:0] byte_data,
    output logic       TX,
    output logic       byte_busy,
    output logic       byte_done
);

    localparam int             CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS);
    localparam logic [3:0]     STOP_IDX  = 4'(DATA_BITS + 1);

    logic [CNT_W-1:0] clk_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shreg;

    // bit_idx: 0 = start bit, 1..8 = data bits, 9 = stop bit
    always_ff @(posedge CLK) begin
        if (RESET) begin
            TX        <= STOP_BIT;
            byte_busy <= 1'b0;
            byte_done <= 1'b0;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            byte_done <= 1'b0;
            if (!byte_busy) begin
                if (byte_start) begin
                    byte_busy <= 1'b1;
                    TX        <= START_BIT;
                    shreg     <= byte_data;
                    clk_cnt   <= '0;
                    bit_idx   <= '0;
                end
            end else begin
                // Registered so the pulse lands in the final stop-bit cycle.
                byte_done <= (bit_idx == STOP_IDX) && (clk_cnt == CNT_DONE);
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt <= '0;
                    if (bit_idx == STOP_IDX) begin
                        byte_busy <= 1'b0;
                        bit_idx   <= '0;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == LAST_DATA) begin
                            TX <= STOP_BIT;
                        end else begin
                            TX    <= shreg[0];
                            shreg <= shreg >> 1;
                        end
                    end
                end else begin
                    clk_cnt <= clk_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_dump_uart_tx.sv
// ============================================================================
// reg_dump_uart_tx : walks the register-file debug port and streams each word
//                    out over UART as four bytes, MSB byte first
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_dump_uart_tx
    import dbg_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIRST_REG    = 0,
    parameter int LAST_REG     = 31
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    output logic [4:0]  DEBUG_ADDR,
    input  logic [31:0] DEBUG_DATA,
    output logic        TX,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
    localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);
    localparam logic [1:0] LAST_BYTE  = 2'(BYTES_PER_REG - 1);

    dump_state_t state;
    logic [31:0] word;
    logic [1:0]  byte_idx;
    logic        byte_start;
    logic [7:0]  byte_data;
    logic        byte_busy;
    logic        byte_done;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            DEBUG_ADDR <= FIRST_ADDR;
            word       <= '0;
            byte_idx   <= '0;
            byte_start <= 1'b0;
            byte_data  <= '0;
        end else begin
            byte_start <= 1'b0;
            DONE       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state      <= ST_SETUP;
                        BUSY       <= 1'b1;
                        DEBUG_ADDR <= FIRST_ADDR;
                    end
                end
                ST_SETUP: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // One snapshot per register; later changes on DEBUG_DATA are not seen.
                    word       <= DEBUG_DATA;
                    byte_idx   <= '0;
                    byte_data  <= word_byte(DEBUG_DATA, 2'd0);
                    byte_start <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (byte_busy) begin
                        byte_start <= 1'b1;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (byte_done) begin
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx   <= byte_idx + 2'd1;
                            byte_data  <= word_byte(word, byte_idx + 2'd1);
                            byte_start <= 1'b1;
                            state      <= ST_SEND;
                        end else if (DEBUG_ADDR == LAST_ADDR) begin
                            DONE  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            DEBUG_ADDR <= DEBUG_ADDR + 5'd1;
                            state      <= ST_SETUP;
                        end
                    end
                end
                ST_FINISH: begin
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .CLK       (CLK),
        .RESET     (RESET),
        .byte_start(byte_start),
        .byte_data (byte_data),
        .TX        (TX),
        .byte_busy (byte_busy),
        .byte_done (byte_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_uart_tx.sv
// ============================================================================
// tb_reg_dump_uart_tx : scoreboard bench decoding the UART line of two dumpers
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_reg_dump_uart_tx;

    localparam int CPB      = 4;
    localparam int BYTE_GAP = 10 * CPB + 1;
    localparam int WORD_GAP = 10 * CPB + 3;
    localparam int HIST     = 20000;

    typedef struct {
        logic [7:0] b;
        bit         snap;
        int         idx;
        int         gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_f = 1'b0, start_o = 1'b0;
    logic [4:0]  addr_f, addr_o;
    logic [31:0] data_f, data_o;
    logic        tx_f, tx_o, busy_f, busy_o, done_f, done_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] regs [32];
    logic [31:0] r31 = 32'h0;
    logic [31:0] hist31 [HIST];
    exp_t        exp_f[$], exp_o[$];
    int          falls_f[$], falls_o[$];
    int          nbytes_f = 0, nbytes_o = 0, dcnt_f = 0, dcnt_o = 0, addr_skips = 0;
    logic [4:0]  last_addr = 5'd0;
    logic        prev_busy = 1'b0;

    always #5 clk = ~clk;

    // REG31 is a free-running random source, new value every cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        r31 <= $urandom;
    end

    always @(negedge clk) begin
        if (cyc < HIST) hist31[cyc] <= r31;
        if (done_f === 1'b1) dcnt_f <= dcnt_f + 1;
        if (done_o === 1'b1) dcnt_o <= dcnt_o + 1;
        if (prev_busy === 1'b1 && busy_f === 1'b1 && addr_f !== last_addr && addr_f !== last_addr + 5'd1)
            addr_skips <= addr_skips + 1;
        last_addr <= addr_f;
        prev_busy <= busy_f;
    end

    assign data_f = (addr_f == 5'd31) ? r31 : regs[addr_f];
    assign data_o = (addr_o == 5'd5) ? 32'hDEADBEEF : 32'h0BAD0BAD;

    reg_dump_uart_tx #(.CLKS_PER_BIT(CPB), .FIRST_REG(0), .LAST_REG(31)) u_full (
        .CLK(clk), .RESET(rst), .START(start_f), .DEBUG_ADDR(addr_f),
        .DEBUG_DATA(data_f), .TX(tx_f), .BUSY(busy_f), .DONE(done_f)
    );

    reg_dump_uart_tx #(.CLKS_PER_BIT(CPB), .FIRST_REG(5), .LAST_REG(5)) u_one (
        .CLK(clk), .RESET(rst), .START(start_o), .DEBUG_ADDR(addr_o),
        .DEBUG_DATA(data_o), .TX(tx_o), .BUSY(busy_o), .DONE(done_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, want);
        end
    endtask

    function automatic logic tx_of(input bit w);
        return w ? tx_o : tx_f;
    endfunction

    // Decodes one frame by sampling each bit at its centre; gives up if reset appears.
    task automatic rx_byte(input bit w, output logic [7:0] b, output logic stop, output int f, output bit ok);
        logic prev;
        int   j;
        prev = tx_of(w);
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && prev === 1'b1 && tx_of(w) === 1'b0) break;
            prev = tx_of(w);
        end
        f = cyc; ok = 1'b1; b = '0; stop = 1'b0;
        if (w) falls_o.push_back(f); else falls_f.push_back(f);
        for (int n = 1; n <= 9 * CPB + CPB / 2; n++) begin
            @(negedge clk);
            if (rst === 1'b1) begin ok = 1'b0; break; end
            if (n >= CPB + CPB / 2 && (n - CPB / 2) % CPB == 0) begin
                j = (n - CPB / 2) / CPB;
                if (j <= 8) b[j-1] = tx_of(w); else stop = tx_of(w);
            end
        end
    endtask

    task automatic monitor(input bit w);
        logic [7:0]  b, want;
        logic        stop;
        int          f, last;
        bit          ok;
        logic [31:0] snap;
        exp_t        e;
        last = 0; snap = '0;
        forever begin
            rx_byte(w, b, stop, f, ok);
            if (ok) begin
                if (w) nbytes_o++; else nbytes_f++;
                chk(w ? "stop_bit_one" : "stop_bit_full", stop, 1);
                if ((w ? exp_o.size() : exp_f.size()) == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_%0d unexpected byte actual=%02h required=none", w, b);
                end else begin
                    e = w ? exp_o.pop_front() : exp_f.pop_front();
                    if (e.snap) begin
                        if (e.idx == 0) snap = (f >= 2 && f - 2 < HIST) ? hist31[f-2] : 32'hx;
                        want = snap[8*(3-e.idx) +: 8];
                    end else begin
                        want = e.b;
                    end
                    chk(w ? "byte_one" : "byte_full", b, want);
                    if (e.gap != 0) chk(w ? "gap_one" : "gap_full", f - last, e.gap);
                end
                last = f;
            end
        end
    endtask

    initial monitor(1'b0);
    initial monitor(1'b1);

    // Expected stream straight from the register contents: 4 bytes per register, MSB first.
    task automatic push_full();
        exp_t e;
        for (int r = 0; r < 32; r++) begin
            for (int k = 0; k < 4; k++) begin
                e.b    = 8'(regs[r] >> (8 * (3 - k)));
                e.snap = (r == 31);
                e.idx  = k;
                e.gap  = (r == 0 && k == 0) ? 0 : ((k == 0) ? WORD_GAP : BYTE_GAP);
                exp_f.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input bit w, output int n);
        @(posedge clk); #1;
        n = cyc;
        if (w) start_o = 1'b1; else start_f = 1'b1;
        @(posedge clk); #1;
        start_o = 1'b0; start_f = 1'b0;
    endtask

    task automatic run_dump(input bit w, input int n0, input int nfall0, input int nbytes0,
                            input int dcnt0, input int want_bytes, input int poke_at, input string tag);
        int t, busy_low, dcyc, lastfall;
        bit seen;
        t = 0; seen = 1'b0; busy_low = 0; dcyc = 0;
        while (!seen && t < 10000) begin
            @(negedge clk); t++;
            if (t == poke_at) begin if (w) start_o = 1'b1; else start_f = 1'b1; end
            if (t == poke_at + 1) begin start_o = 1'b0; start_f = 1'b0; end
            if ((w ? done_o : done_f) === 1'b1) begin seen = 1'b1; dcyc = cyc; end
            else if ((w ? busy_o : busy_f) !== 1'b1) busy_low++;
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_busy_high"}, busy_low, 0);
        chk({tag, "_start_to_tx"}, (w ? falls_o[nfall0] : falls_f[nfall0]) - n0, 4);
        lastfall = w ? falls_o[$] : falls_f[$];
        chk({tag, "_done_after_stop"}, dcyc - lastfall, 10 * CPB);
        @(negedge clk);
        chk({tag, "_busy_clear"}, w ? busy_o : busy_f, 0);
        chk({tag, "_done_one_cycle"}, w ? done_o : done_f, 0);
        repeat (60) @(negedge clk);
        chk({tag, "_byte_count"}, (w ? nbytes_o : nbytes_f) - nbytes0, want_bytes);
        chk({tag, "_done_count"}, (w ? dcnt_o : dcnt_f) - dcnt0, 1);
        chk({tag, "_sb_drain"}, w ? exp_o.size() : exp_f.size(), 0);
    endtask

    initial begin : stim
        int   n0, nf, t, d0, idle_bad;
        exp_t e;

        for (int i = 0; i < 32; i++) regs[i] = 32'h01010101 * i;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_full", tx_f, 1);
        chk("rst_busy_full", busy_f, 0);
        chk("rst_done_full", done_f, 0);
        chk("rst_addr_full", addr_f, 0);
        chk("rst_tx_one", tx_o, 1);
        chk("rst_addr_one", addr_o, 5);

        idle_bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_f !== 1'b1 || tx_o !== 1'b1 || busy_f !== 1'b0 || done_f !== 1'b0) idle_bad++;
        end
        chk("idle_quiet", idle_bad, 0);

        // Single-register dump of 0xDEADBEEF.
        e.snap = 1'b0; e.idx = 0;
        e.b = 8'hDE; e.gap = 0;        exp_o.push_back(e);
        e.b = 8'hAD; e.gap = BYTE_GAP; exp_o.push_back(e);
        e.b = 8'hBE; e.gap = BYTE_GAP; exp_o.push_back(e);
        e.b = 8'hEF; e.gap = BYTE_GAP; exp_o.push_back(e);
        nf = falls_o.size(); d0 = dcnt_o; t = nbytes_o;
        pulse_start(1'b1, n0);
        run_dump(1'b1, n0, nf, t, d0, 4, 0, "single");
        chk("single_addr", addr_o, 5);

        // Full dump with a second START issued mid-dump.
        push_full();
        nf = falls_f.size(); d0 = dcnt_f; t = nbytes_f;
        pulse_start(1'b0, n0);
        run_dump(1'b0, n0, nf, t, d0, 128, 300, "full");
        chk("full_addr_last", addr_f, 31);
        chk("full_addr_no_skip", addr_skips, 0);

        // Reset during data bit 3 of the third byte.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        push_full();
        nf = falls_f.size();
        pulse_start(1'b0, n0);
        t = 0;
        while (falls_f.size() < nf + 3 && t < 2000) begin @(negedge clk); t++; end
        chk("abort_reach_byte2", (falls_f.size() >= nf + 3) ? 1 : 0, 1);
        if (falls_f.size() >= nf + 3) begin
            while (cyc < falls_f[nf+2] + 4 * CPB) begin @(posedge clk); #1; end
        end
        d0 = dcnt_f;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_tx", tx_f, 1);
        chk("abort_busy", busy_f, 0);
        chk("abort_addr", addr_f, 0);
        chk("abort_done", done_f, 0);
        repeat (50) @(negedge clk);
        chk("abort_no_done", dcnt_f - d0, 0);
        chk("abort_tx_idle", tx_f, 1);
        exp_f.delete();

        // Clean dump after the abort.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        push_full();
        nf = falls_f.size(); d0 = dcnt_f; t = nbytes_f;
        pulse_start(1'b0, n0);
        run_dump(1'b0, n0, nf, t, d0, 128, 0, "after_abort");
        chk("after_abort_addr_no_skip", addr_skips, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
